// File: rtl/multdiv_ctrl.sv
// Sequencer and result collector for the shared multiply/divide unit: latches
// operands, steps the selected datapath's iteration count and returns its result.
module multdiv_ctrl (
    input  logic        clock,
    input  logic        dataReset_n,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] mult_multiplicand,
    output logic [31:0] mult_multiplier,
    output logic [3:0]  mult_count,
    input  logic [31:0] mult_result,
    input  logic        mult_overflow,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    output logic [5:0]  div_count,
    input  logic [31:0] div_quotient,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);
    localparam int unsigned MULT_CYCLES = 17;
    localparam int unsigned DIV_CYCLES  = 33;
    localparam int unsigned CNT_W       = 6;
    localparam int unsigned MCNT_W      = 4;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned MCNT_MAX    = 15;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   mult_a_q, mult_a_d;
    logic [DATA_W-1:0]   mult_b_q, mult_b_d;
    logic [DATA_W-1:0]   div_a_q, div_a_d;
    logic [DATA_W-1:0]   div_b_q, div_b_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                exc_q, exc_d;
    logic                rdy_q, rdy_d;
    logic                busy_q, busy_d;
    logic [MCNT_W-1:0]   mult_count_q, mult_count_d;
    logic [CNT_W-1:0]    div_count_q, div_count_d;

    // Next-state logic: a new request always wins over the running operation.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mult_a_d = mult_a_q;
        mult_b_d = mult_b_q;
        div_a_d  = div_a_q;
        div_b_d  = div_b_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;

        if (ctrl_MULT) begin
            mult_a_d = data_operandA;
            mult_b_d = data_operandB;
            cnt_d    = '0;
            state_d  = S_MULT;
        end else if (ctrl_DIV) begin
            div_a_d = data_operandA;
            div_b_d = data_operandB;
            cnt_d   = '0;
            if (data_operandB == '0) begin
                // Divide-by-zero completes immediately without running the divider.
                result_d = '0;
                exc_d    = 1'b1;
                rdy_d    = 1'b1;
                state_d  = S_DONE;
            end else begin
                state_d = S_DIV;
            end
        end else begin
            case (state_q)
                S_IDLE: state_d = S_IDLE;
                S_MULT: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(MULT_CYCLES - 1)) begin
                        result_d = mult_result;
                        exc_d    = mult_overflow;
                        rdy_d    = 1'b1;
                        state_d  = S_DONE;
                    end
                end
                S_DIV: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DIV_CYCLES - 1)) begin
                        result_d = div_quotient;
                        exc_d    = 1'b0;
                        rdy_d    = 1'b1;
                        state_d  = S_DONE;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Datapath-facing counts are decoded from the next state so they leave flops.
    always_comb begin
        busy_d       = (state_d == S_MULT) || (state_d == S_DIV);
        mult_count_d = '0;
        div_count_d  = '0;
        if (state_d == S_MULT) begin
            // Saturate at the last iteration so the multiplier never sees a reload.
            if (cnt_d > CNT_W'(MCNT_MAX)) begin
                mult_count_d = MCNT_W'(MCNT_MAX);
            end else begin
                mult_count_d = cnt_d[MCNT_W-1:0];
            end
        end
        if (state_d == S_DIV) begin
            div_count_d = cnt_d;
        end
    end

    always_ff @(posedge clock or negedge dataReset_n) begin
        if (!dataReset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            mult_a_q     <= '0;
            mult_b_q     <= '0;
            div_a_q      <= '0;
            div_b_q      <= '0;
            result_q     <= '0;
            exc_q        <= 1'b0;
            rdy_q        <= 1'b0;
            busy_q       <= 1'b0;
            mult_count_q <= '0;
            div_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mult_a_q     <= mult_a_d;
            mult_b_q     <= mult_b_d;
            div_a_q      <= div_a_d;
            div_b_q      <= div_b_d;
            result_q     <= result_d;
            exc_q        <= exc_d;
            rdy_q        <= rdy_d;
            busy_q       <= busy_d;
            mult_count_q <= mult_count_d;
            div_count_q  <= div_count_d;
        end
    end

    assign mult_multiplicand = mult_a_q;
    assign mult_multiplier   = mult_b_q;
    assign mult_count        = mult_count_q;
    assign div_dividend      = div_a_q;
    assign div_divisor       = div_b_q;
    assign div_count         = div_count_q;
    assign data_result       = result_q;
    assign data_exception    = exc_q;
    assign data_resultRDY    = rdy_q;
    assign busy              = busy_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Scoreboard bench for multdiv_ctrl with behavioural multiply/divide datapath stubs.
module tb_multdiv_ctrl;
    localparam int MULT_CYCLES = 17;
    localparam int DIV_CYCLES  = 33;

    logic        clock = 1'b0;
    logic        dataReset_n = 1'b0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] mult_multiplicand, mult_multiplier, mult_result;
    logic [3:0]  mult_count;
    logic        mult_overflow;
    logic [31:0] div_dividend, div_divisor, div_quotient;
    logic [5:0]  div_count;
    logic [31:0] data_result;
    logic        data_exception, data_resultRDY, busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          win_kind = 0;
    int          win_lo = 0;
    int          win_hi = -1;
    logic [31:0] e_ma = '0, e_mb = '0, e_da = '0, e_db = '0;
    logic [31:0] hold_res = '0;
    logic        hold_exc = 1'b0;
    int          mstep = 0;
    logic        exp_busy;
    logic [3:0]  exp_mc;
    logic [5:0]  exp_dc;
    exp_t        popped;
    logic [32:0] mref;

    multdiv_ctrl dut (
        .clock             (clock),
        .dataReset_n       (dataReset_n),
        .ctrl_MULT         (ctrl_MULT),
        .ctrl_DIV          (ctrl_DIV),
        .data_operandA     (data_operandA),
        .data_operandB     (data_operandB),
        .mult_multiplicand (mult_multiplicand),
        .mult_multiplier   (mult_multiplier),
        .mult_count        (mult_count),
        .mult_result       (mult_result),
        .mult_overflow     (mult_overflow),
        .div_dividend      (div_dividend),
        .div_divisor       (div_divisor),
        .div_count         (div_count),
        .div_quotient      (div_quotient),
        .data_result       (data_result),
        .data_exception    (data_exception),
        .data_resultRDY    (data_resultRDY),
        .busy              (busy)
    );

    always #5 clock = ~clock;

    // {overflow, low product} of a signed 32x32 multiply
    function automatic logic [32:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return {(p != longint'($signed(p[31:0]))), p[31:0]};
    endfunction

    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        longint d;
        if (b == 32'd0) return 32'd0;
        d = longint'($signed(a)) / longint'($signed(b));
        return d[31:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Datapath stubs: correct values appear only on the final iteration.
    always @(posedge clock) begin
        if (mult_count == 4'd0) mstep <= 1;
        else if (mstep < 100) mstep <= mstep + 1;
    end
    wire [32:0] stub_m = ref_mul(mult_multiplicand, mult_multiplier);
    wire        m_last = (mstep == 16) && (mult_count == 4'd15);
    assign mult_result   = m_last ? stub_m[31:0] : (stub_m[31:0] ^ 32'hA5A5_0F0F);
    assign mult_overflow = m_last ? stub_m[32] : ~stub_m[32];
    assign div_quotient  = (div_count == 6'd32) ? ref_div(div_dividend, div_divisor)
                                                : ~ref_div(div_dividend, div_divisor);

    // Reference model: on each sampled request, predict the result and its RDY cycle.
    always @(posedge clock) begin
        cyc = cyc + 1;
        if (!dataReset_n) begin
            sb.delete();
            win_kind = 0;
            e_ma = '0; e_mb = '0; e_da = '0; e_db = '0;
            hold_res = '0; hold_exc = 1'b0;
        end else if (ctrl_MULT || ctrl_DIV) begin
            while (sb.size() > 0 && sb[$].cyc >= cyc) void'(sb.pop_back());
            if (ctrl_MULT) begin
                mref = ref_mul(data_operandA, data_operandB);
                e_ma = data_operandA;
                e_mb = data_operandB;
                sb.push_back('{mref[31:0], mref[32], cyc + MULT_CYCLES});
                win_kind = 1; win_lo = cyc; win_hi = cyc + MULT_CYCLES - 1;
            end else begin
                e_da = data_operandA;
                e_db = data_operandB;
                if (data_operandB == 32'd0) begin
                    sb.push_back('{32'd0, 1'b1, cyc});
                    win_kind = 0;
                end else begin
                    sb.push_back('{ref_div(data_operandA, data_operandB), 1'b0, cyc + DIV_CYCLES});
                    win_kind = 2; win_lo = cyc; win_hi = cyc + DIV_CYCLES - 1;
                end
            end
        end
    end

    // Monitor: per-cycle status checks and scoreboard pop on RDY.
    always @(negedge clock) begin
        if (dataReset_n === 1'b1) begin
            exp_busy = 1'b0; exp_mc = 4'd0; exp_dc = 6'd0;
            if (win_kind != 0 && cyc >= win_lo && cyc <= win_hi) begin
                exp_busy = 1'b1;
                if (win_kind == 1) exp_mc = (cyc - win_lo > 15) ? 4'd15 : 4'(cyc - win_lo);
                else exp_dc = 6'(cyc - win_lo);
            end
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("mult_count", 32'(mult_count), 32'(exp_mc));
            chk("div_count", 32'(div_count), 32'(exp_dc));
            chk("mult_multiplicand", mult_multiplicand, e_ma);
            chk("mult_multiplier", mult_multiplier, e_mb);
            chk("div_dividend", div_dividend, e_da);
            chk("div_divisor", div_divisor, e_db);
            if (data_resultRDY) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rdy", 32'(data_resultRDY), 32'd0);
                end else begin
                    popped = sb.pop_front();
                    chk("rdy_cycle", 32'(cyc), 32'(popped.cyc));
                    chk("result", data_result, popped.res);
                    chk("exception", 32'(data_exception), 32'(popped.exc));
                    hold_res = popped.res;
                    hold_exc = popped.exc;
                end
            end else begin
                if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                    chk("missing_rdy", 32'(data_resultRDY), 32'd1);
                    void'(sb.pop_front());
                end
                chk("result_hold", data_result, hold_res);
                chk("exception_hold", 32'(data_exception), 32'(hold_exc));
            end
        end
    end

    task automatic req(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
        @(posedge clock); #1;
        ctrl_MULT = m; ctrl_DIV = d; data_operandA = a; data_operandB = b;
        @(posedge clock); #1;
        ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
        data_operandA = $urandom; data_operandB = $urandom;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
    endtask

    task automatic chk_all_reset(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_rdy"}, 32'(data_resultRDY), 32'd0);
        chk({tag, "_result"}, data_result, 32'd0);
        chk({tag, "_exception"}, 32'(data_exception), 32'd0);
        chk({tag, "_mult_count"}, 32'(mult_count), 32'd0);
        chk({tag, "_div_count"}, 32'(div_count), 32'd0);
        chk({tag, "_multiplicand"}, mult_multiplicand, 32'd0);
        chk({tag, "_multiplier"}, mult_multiplier, 32'd0);
        chk({tag, "_dividend"}, div_dividend, 32'd0);
        chk({tag, "_divisor"}, div_divisor, 32'd0);
    endtask

    initial begin
        bit          found;
        int          k;
        logic [31:0] a, b;

        #7;
        chk_all_reset("reset");
        @(negedge clock); @(negedge clock); #1;
        dataReset_n = 1'b1;

        req(1, 0, 32'd7, -32'sd3);           idle(22);
        req(1, 0, 32'h0001_0000, 32'h0001_0000); idle(22);
        req(0, 1, 32'd100, 32'd7);           idle(38);
        req(0, 1, 32'd5, 32'd0);             idle(4);
        req(1, 0, 32'd3, 32'd4);             idle(4);
        req(0, 1, 32'd9, 32'd3);             idle(38);
        req(1, 1, 32'd6, 32'd2);             idle(22);

        // Restart with a request sampled in the DONE cycle.
        req(1, 0, 32'd11, 32'd13);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clock);
            if (data_resultRDY) found = 1'b1;
        end
        if (!found) chk("done_wait_timeout", 32'(found), 32'd1);
        ctrl_DIV = 1'b1; data_operandA = 32'd50; data_operandB = 32'd5;
        @(posedge clock); #1;
        ctrl_DIV = 1'b0; data_operandA = $urandom; data_operandB = $urandom;
        idle(38);

        // Asynchronous reset in the middle of a multiply.
        req(1, 0, 32'd123, 32'd456);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clock);
            if (mult_count == 4'd9) found = 1'b1;
        end
        if (!found) chk("count9_wait_timeout", 32'(found), 32'd1);
        #2 dataReset_n = 1'b0;
        #1 chk_all_reset("async_reset");
        idle(2);
        @(negedge clock); #1;
        dataReset_n = 1'b1;
        idle(25);

        for (int i = 0; i < 30; i++) begin
            k = $urandom_range(0, 9);
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                a = 32'($urandom_range(0, 4000)) - 32'd2000;
                b = 32'($urandom_range(1, 300));
            end
            if (k <= 3)      req(1, 0, a, b);
            else if (k <= 6) req(0, 1, a, (b == 32'd0) ? 32'd1 : b);
            else if (k == 7) req(0, 1, a, 32'd0);
            else             req(1, 1, a, b);
            idle($urandom_range(0, 40));
        end
        idle(40);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
